regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Writeback arbiter directly upstream of the register file's single write port.
//  - Merges two result sources: single-cycle ALU results and long-latency results (load/mul/div).
//  - Queues long-latency results in a small FIFO and resolves write-after-write (WAW) ordering.
//  - Exports a pending-register mask so decode can detect hazards.
// PARAMETERS
//  LQ_DEPTH   4   long-result FIFO entries (power of 2, >=2)
//  STARVE_MAX 8   consecutive ALU-priority cycles before alu_stall (only with WB_STARVE_LIMIT_EN)
// PORTS
//  clk        in   1   single clock, all state on posedge
//  rst        in   1   synchronous, active-high reset
//  alu_valid  in   1   ALU result present; always accepted (no ready)
//  alu_num    in   5   ALU destination register
//  alu_data   in   32  ALU result
//  lng_valid  in   1   long-latency result offered
//  lng_ready  out  1   long-latency result accepted when lng_valid&&lng_ready
//  lng_num    in   5   long-latency destination register
//  lng_data   in   32  long-latency result
//  wr_en      out  1   to regfile wr_en (registered)
//  wr_num     out  5   to regfile wr_num (registered)
//  wr_data    out  32  to regfile wr_data (registered)
//  pend_mask  out  32  bit n=1: live queued result for register n
//  lq_count   out  3   FIFO occupancy, 0..LQ_DEPTH, width $clog2(LQ_DEPTH)+1
//  alu_stall  out  1   request upstream to withhold alu_valid next cycle
// BEHAVIOUR
//  - Reset: wr_en=0, wr_num=0, wr_data=0, FIFO emptied, lq_count=0, pend_mask=0, alu_stall=0,
//    starve counter=0. lng_ready=0 while rst=1. In-flight entries are discarded on reset mid-operation.
//  - Latency: one cycle from input to wr_* outputs. At most one regfile write per cycle.
//  - Select order each cycle:
//    1. alu_valid: write ALU result.
//    2. Else FIFO non-empty: pop the head.
//    3. Else lng accepted this cycle: bypass straight to wr_* without enqueue.
//  - lng_ready = !full, computed from registered count; no same-cycle pop-to-push passthrough.
//  - Enqueue rule: a long result enqueues when accepted and not bypassed. lng_num==0 is accepted
//    and dropped; it is never enqueued or written.
//  - alu_num==0 produces wr_en=0.
//  - Each FIFO entry holds {live, num, data}.
//  - WAW squash: an ALU write to reg n (n!=0) clears live on every queued entry with num==n.
//  - Simultaneous ALU and accepted lng with the same num: the ALU result wins and the lng result is
//    dropped.
//  - Popping a non-live entry consumes the cycle: wr_en=0 and the count decrements.
//  - Push and pop in the same cycle: count unchanged. Pointers wrap modulo LQ_DEPTH.
//  - Full: lng_ready=0 and the offered result is held by the producer. Empty: no pop.
//  - pend_mask: combinational OR over live entries of (1<<num). Bit 0 is always 0.
//    The bypass/output register is not included.
// CONFIGURATION
//  WB_STARVE_LIMIT_EN defined:
//  - Starve counter increments on each cycle where the FIFO is non-empty and alu_valid=1.
//  - The counter clears on any pop.
//  - alu_stall is registered, =1 once the counter reaches STARVE_MAX.
//  - While alu_stall=1, upstream keeps alu_valid=0, so the next cycle pops.
//  - If alu_valid arrives anyway, the ALU still wins; this is a protocol violation flagged by an
//    assertion.
//  WB_STARVE_LIMIT_EN undefined: alu_stall tied 0, no counter; the FIFO may starve indefinitely.
// TESTING
//  1. Reset, then alu_valid,num=5,data=0xA5A5 -> next cycle wr_en=1,wr_num=5,wr_data=0xA5A5; then wr_en=0.
//  2. Idle, lng num=7,data=0x11 -> lng_ready=1; next cycle wr 7=0x11; lq_count stays 0 (bypass).
//  3. alu_valid held 6 cycles, lng pushes r1..r4 -> lng_ready=0 after 4 accepts; pend_mask=0x1E;
//     drain writes r1,r2,r3,r4 in order.
//  4. Queue r9=0x99, then ALU r9=0x42 -> pend_mask[9]=0; final r9=0x42; popping the squashed entry
//     gives wr_en=0.
//  5. Same cycle ALU r3=1 and lng r3=2 -> wr r3=1 only; lq_count=0. lng r0 -> no write, no enqueue.
//  6. WB_STARVE_LIMIT_EN, STARVE_MAX=8: FIFO non-empty with alu_valid=1 every cycle -> alu_stall=1
//     after 8 cycles; when alu_valid drops, head pops and alu_stall returns to 0.
//     Mid-run rst -> lq_count=0, pend_mask=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Writeback arbiter sitting directly in front of the register file's single
// write port. Single-cycle ALU results always win the port; long-latency
// results (load/mul/div) are queued in a small FIFO, drained when the ALU is
// idle, and bypassed straight to the port when nothing else competes.
// Write-after-write ordering is kept by killing queued results whose
// destination is overwritten by a younger ALU write.
//
// Optional feature macro: WB_STARVE_LIMIT_EN
//   When defined, a starvation counter asks upstream to withhold ALU results
//   (o_alu_stall) after STARVE_MAX consecutive cycles in which the ALU kept a
//   non-empty FIFO from draining. When undefined, o_alu_stall is tied to 0.
//
// Parameters
//   LQ_DEPTH    long-result FIFO entries (power of 2, >= 2)
//   STARVE_MAX  ALU-priority cycles tolerated before o_alu_stall rises
//
// Ports
//   i_clk         clock, all state on the rising edge
//   i_rst         synchronous active-high reset
//   i_alu_valid   ALU result present (always accepted)
//   i_alu_num     ALU destination register
//   i_alu_data    ALU result
//   i_lng_valid   long-latency result offered
//   o_lng_ready   long-latency result accepted when valid && ready
//   i_lng_num     long-latency destination register
//   i_lng_data    long-latency result
//   o_wr_en       register file write enable (registered)
//   o_wr_num      register file write index (registered)
//   o_wr_data     register file write data (registered)
//   o_pend_mask   bit n set: a live queued result targets register n
//   o_lq_count    FIFO occupancy, 0..LQ_DEPTH
//   o_alu_stall   ask upstream to withhold i_alu_valid next cycle

module regfile_wb_arbiter #(
   parameter int LQ_DEPTH   = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_alu_valid,
   input  logic [4:0]                  i_alu_num,
   input  logic [31:0]                 i_alu_data,
   input  logic                        i_lng_valid,
   output logic                        o_lng_ready,
   input  logic [4:0]                  i_lng_num,
   input  logic [31:0]                 i_lng_data,
   output logic                        o_wr_en,
   output logic [4:0]                  o_wr_num,
   output logic [31:0]                 o_wr_data,
   output logic [31:0]                 o_pend_mask,
   output logic [$clog2(LQ_DEPTH):0]   o_lq_count,
   output logic                        o_alu_stall
);

   localparam int PW = $clog2(LQ_DEPTH);
   localparam int CW = PW + 1;

   // FIFO storage: each slot carries {live, num, data}
   logic              r_live [LQ_DEPTH];
   logic [4:0]        r_num  [LQ_DEPTH];
   logic [31:0]       r_data [LQ_DEPTH];
   logic [PW-1:0]     r_head;
   logic [PW-1:0]     r_tail;
   logic [CW-1:0]     r_count;

   // Registered write port
   logic              r_wr_en;
   logic [4:0]        r_wr_num;
   logic [31:0]       r_wr_data;

   logic              w_full;
   logic              w_empty;
   logic              w_lng_acc;
   logic              w_sel_pop;
   logic              w_sel_byp;
   logic              w_push;
   logic              w_squash;
   logic              w_wr_en;
   logic [4:0]        w_wr_num;
   logic [31:0]       w_wr_data;
   logic [31:0]       w_pend_mask;

   // Ready depends only on the registered occupancy, so a slot freed by this
   // cycle's pop is not offered to the producer until the next cycle.
   assign w_full      = (r_count == CW'(LQ_DEPTH));
   assign w_empty     = (r_count == '0);
   assign o_lng_ready = !i_rst && !w_full;
   assign w_lng_acc   = i_lng_valid && o_lng_ready;

   // Port ownership: ALU first, then the FIFO head, then a direct bypass of
   // the incoming long result when the queue is empty and the ALU is idle.
   assign w_sel_pop = !i_alu_valid && !w_empty;
   assign w_sel_byp = !i_alu_valid && w_empty && w_lng_acc;

   // An accepted long result that did not take the port is queued, unless it
   // targets r0 or collides with the ALU result written this same cycle (the
   // younger ALU value wins, so the long value would only be squashed later).
   assign w_push   = w_lng_acc && !w_sel_byp && (i_lng_num != 5'd0) &&
                     !(i_alu_valid && (i_alu_num == i_lng_num));
   assign w_squash = i_alu_valid && (i_alu_num != 5'd0);

   // Next write-port value; popping a squashed entry still uses the cycle but
   // produces no write.
   always_comb begin
      w_wr_en   = 1'b0;
      w_wr_num  = '0;
      w_wr_data = '0;
      if (i_alu_valid) begin
         w_wr_en   = (i_alu_num != 5'd0);
         w_wr_num  = i_alu_num;
         w_wr_data = i_alu_data;
      end else if (w_sel_pop) begin
         w_wr_en   = r_live[r_head];
         w_wr_num  = r_num[r_head];
         w_wr_data = r_data[r_head];
      end else if (w_sel_byp) begin
         w_wr_en   = (i_lng_num != 5'd0);
         w_wr_num  = i_lng_num;
         w_wr_data = i_lng_data;
      end
   end

   // Write-port register; index and data only move when a write happens.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_en   <= 1'b0;
         r_wr_num  <= '0;
         r_wr_data <= '0;
      end else begin
         r_wr_en <= w_wr_en;
         if (w_wr_en) begin
            r_wr_num  <= w_wr_num;
            r_wr_data <= w_wr_data;
         end
      end
   end

   // FIFO state. Squash only happens on ALU cycles, which never pop, and the
   // push slot is always free, so the later push assignment safely overrides
   // any squash of a stale tail slot.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < LQ_DEPTH; i++) begin
            r_live[i] <= 1'b0;
            r_num[i]  <= '0;
            r_data[i] <= '0;
         end
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         for (int i = 0; i < LQ_DEPTH; i++) begin
            if (w_squash && (r_num[i] == i_alu_num)) begin
               r_live[i] <= 1'b0;
            end
         end
         if (w_sel_pop) begin
            r_live[r_head] <= 1'b0;
            r_head         <= r_head + PW'(1);
         end
         if (w_push) begin
            r_live[r_tail] <= 1'b1;
            r_num[r_tail]  <= i_lng_num;
            r_data[r_tail] <= i_lng_data;
            r_tail         <= r_tail + PW'(1);
         end
         case ({w_push, w_sel_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Pending mask for decode hazard checks; only live slots contribute, and
   // popped slots have their live bit cleared so stale slots never show up.
   always_comb begin
      w_pend_mask = '0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
         if (r_live[i]) begin
            w_pend_mask[r_num[i]] = 1'b1;
         end
      end
      w_pend_mask[0] = 1'b0;
   end

   assign o_wr_en     = r_wr_en;
   assign o_wr_num    = r_wr_num;
   assign o_wr_data   = r_wr_data;
   assign o_pend_mask = w_pend_mask;
   assign o_lq_count  = r_count;

`ifdef WB_STARVE_LIMIT_EN
   localparam int SW = $clog2(STARVE_MAX + 1);

   logic [SW-1:0] r_starve_cnt;
   logic [SW-1:0] w_starve_nxt;
   logic          r_alu_stall;

   // Count cycles where the ALU kept a non-empty FIFO from draining; any pop
   // restarts the count. Saturates so the stall stays up until a pop.
   always_comb begin
      w_starve_nxt = r_starve_cnt;
      if (w_sel_pop) begin
         w_starve_nxt = '0;
      end else if (!w_empty && i_alu_valid && (r_starve_cnt != SW'(STARVE_MAX))) begin
         w_starve_nxt = r_starve_cnt + SW'(1);
      end
   end

   // Stall is registered so upstream sees it at the start of the next cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_starve_cnt <= '0;
         r_alu_stall  <= 1'b0;
      end else begin
         r_starve_cnt <= w_starve_nxt;
         r_alu_stall  <= (w_starve_nxt == SW'(STARVE_MAX));
      end
   end

   assign o_alu_stall = r_alu_stall;

   // The ALU still wins if upstream ignores the stall, but that breaks the
   // forward-progress guarantee for queued results.
   a_stall_respected: assert property (@(posedge i_clk) disable iff (i_rst)
      !(r_alu_stall && i_alu_valid));
`else
   logic [31:0] w_unused_starve_max;
   assign w_unused_starve_max = 32'(STARVE_MAX);
   assign o_alu_stall         = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table, a few
// hand-written multi-cycle sequences, and a randomized run compared against a
// queue-based reference model of the writeback rules.

module tb_regfile_wb_arbiter;

   localparam int LQ_DEPTH   = 4;
   localparam int STARVE_MAX = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_num;
   logic [31:0] alu_data;
   logic        lng_valid;
   logic        lng_ready;
   logic [4:0]  lng_num;
   logic [31:0] lng_data;
   logic        wr_en;
   logic [4:0]  wr_num;
   logic [31:0] wr_data;
   logic [31:0] pend_mask;
   logic [2:0]  lq_count;
   logic        alu_stall;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        live;
      logic [4:0]  num;
      logic [31:0] data;
   } ent_t;

   typedef struct {
      logic        av;
      logic [4:0]  an;
      logic [31:0] ad;
      logic        lv;
      logic [4:0]  ln;
      logic [31:0] ld;
      logic        eEn;
      logic [4:0]  eNum;
      logic [31:0] eData;
      logic [2:0]  eCnt;
   } vec_t;

   // Reference model state
   ent_t        mq[$];
   int          mStarve;
   logic        mStall;
   logic [31:0] dutRf [32];

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.LQ_DEPTH(LQ_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_alu_valid(alu_valid), .i_alu_num(alu_num), .i_alu_data(alu_data),
      .i_lng_valid(lng_valid), .o_lng_ready(lng_ready),
      .i_lng_num(lng_num), .i_lng_data(lng_data),
      .o_wr_en(wr_en), .o_wr_num(wr_num), .o_wr_data(wr_data),
      .o_pend_mask(pend_mask), .o_lq_count(lq_count), .o_alu_stall(alu_stall)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] modelMask();
      logic [31:0] m = '0;
      foreach (mq[i]) if (mq[i].live) m |= (32'd1 << mq[i].num);
      return m;
   endfunction

   task automatic checkOutput(input logic expEn, input logic [4:0] expNum, input logic [31:0] expData);
      check("wr_en", 32'(wr_en), 32'(expEn));
      if (expEn) begin
         check("wr_num", 32'(wr_num), 32'(expNum));
         check("wr_data", wr_data, expData);
      end
      check("alu_stall", 32'(alu_stall), 32'(mStall));
      if (wr_en) dutRf[wr_num] = wr_data;
   endtask

   // One clock cycle: drive inputs, check combinational outputs against the
   // model's current state, advance the model, then check the registered port.
   task automatic applyStimulus(input logic av, input logic [4:0] an, input logic [31:0] ad,
                                input logic lv, input logic [4:0] ln, input logic [31:0] ld,
                                output logic accepted);
      logic        expEn;
      logic [4:0]  expNum;
      logic [31:0] expData;
      logic        nonEmpty;
      logic        popped;
      ent_t        e;
      alu_valid = av; alu_num = an; alu_data = ad;
      lng_valid = lv; lng_num = ln; lng_data = ld;
      #1;
      check("lq_count", 32'(lq_count), 32'(mq.size()));
      check("pend_mask", pend_mask, modelMask());
      check("lng_ready", 32'(lng_ready), 32'(mq.size() < LQ_DEPTH));
      accepted = lv && (mq.size() < LQ_DEPTH);
      nonEmpty = (mq.size() > 0);
      popped = 1'b0;
      expEn = 1'b0; expNum = '0; expData = '0;
      if (av) begin
         expEn = (an != 0); expNum = an; expData = ad;
         if (an != 0) foreach (mq[i]) if (mq[i].num == an) mq[i].live = 1'b0;
         if (accepted && ln != 0 && ln != an) mq.push_back('{live: 1'b1, num: ln, data: ld});
      end else if (nonEmpty) begin
         e = mq.pop_front();
         popped = 1'b1;
         expEn = e.live; expNum = e.num; expData = e.data;
         if (accepted && ln != 0) mq.push_back('{live: 1'b1, num: ln, data: ld});
      end else if (accepted) begin
         expEn = (ln != 0); expNum = ln; expData = ld;
      end
`ifdef WB_STARVE_LIMIT_EN
      if (popped) mStarve = 0;
      else if (nonEmpty && av && mStarve < STARVE_MAX) mStarve++;
      mStall = (mStarve >= STARVE_MAX);
`else
      mStall = 1'b0;
`endif
      @(posedge clk);
      #1;
      checkOutput(expEn, expNum, expData);
   endtask

   task automatic doReset();
      rst = 1'b1;
      alu_valid = 1'b0; alu_num = '0; alu_data = '0;
      lng_valid = 1'b1; lng_num = 5'd2; lng_data = 32'h5;
      @(posedge clk);
      #1;
      check("lng_ready in reset", 32'(lng_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      lng_valid = 1'b0;
      mq.delete();
      mStarve = 0;
      mStall = 1'b0;
      check("reset wr_en", 32'(wr_en), 32'd0);
      check("reset wr_num", 32'(wr_num), 32'd0);
      check("reset wr_data", wr_data, 32'd0);
      check("reset lq_count", 32'(lq_count), 32'd0);
      check("reset pend_mask", pend_mask, 32'd0);
      check("reset alu_stall", 32'(alu_stall), 32'd0);
   endtask

   initial begin
      vec_t        vecs[10];
      logic        acc;
      logic        pv;
      logic [4:0]  pn;
      logic [31:0] pd;
      logic        av;
      int          pct;

      foreach (dutRf[i]) dutRf[i] = '0;

      vecs[0] = '{1'b1, 5'd5, 32'hA5A5, 1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 32'hA5A5, 3'd0};
      vecs[1] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,    3'd0};
      vecs[2] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h11,   3'd0};
      vecs[3] = '{1'b1, 5'd3, 32'h1,    1'b1, 5'd3, 32'h2,  1'b1, 5'd3, 32'h1,    3'd0};
      vecs[4] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,    3'd0};
      vecs[5] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0,    3'd0};
      vecs[6] = '{1'b1, 5'd0, 32'h77,   1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,    3'd0};
      vecs[7] = '{1'b1, 5'd4, 32'h44,   1'b1, 5'd6, 32'h66, 1'b1, 5'd4, 32'h44,   3'd1};
      vecs[8] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  1'b1, 5'd6, 32'h66,   3'd0};
      vecs[9] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,    3'd0};

      doReset();

      // Directed table: ALU write, bypass, same-register collision, r0 drops,
      // ALU-vs-long arbitration with a later drain.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].av, vecs[i].an, vecs[i].ad, vecs[i].lv, vecs[i].ln, vecs[i].ld, acc);
         check($sformatf("vec%0d wr_en", i), 32'(wr_en), 32'(vecs[i].eEn));
         if (vecs[i].eEn) begin
            check($sformatf("vec%0d wr_num", i), 32'(wr_num), 32'(vecs[i].eNum));
            check($sformatf("vec%0d wr_data", i), wr_data, vecs[i].eData);
         end
         check($sformatf("vec%0d lq_count", i), 32'(lq_count), 32'(vecs[i].eCnt));
      end

      // Fill under ALU pressure, then drain in order.
      doReset();
      for (int c = 0; c < 6; c++) begin
         applyStimulus(1'b1, 5'(20 + c), 32'(c), c < 4, 5'(c + 1), 32'(32'h101 + c), acc);
         if (c == 3) begin
            check("fill lng_ready", 32'(lng_ready), 32'd0);
            check("fill pend_mask", pend_mask, 32'h1E);
            check("fill lq_count", 32'(lq_count), 32'd4);
         end
      end
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
         check("drain wr_en", 32'(wr_en), 32'd1);
         check("drain wr_num", 32'(wr_num), 32'(k + 1));
         check("drain wr_data", wr_data, 32'(32'h101 + k));
      end
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
      check("drained wr_en", 32'(wr_en), 32'd0);
      check("drained lq_count", 32'(lq_count), 32'd0);

      // WAW squash of a queued r9.
      doReset();
      applyStimulus(1'b1, 5'd20, 32'h20, 1'b1, 5'd9, 32'h99, acc);
      check("waw queued mask", pend_mask, 32'h200);
      applyStimulus(1'b1, 5'd9, 32'h42, 1'b0, 5'd0, 32'd0, acc);
      check("waw alu wr_num", 32'(wr_num), 32'd9);
      check("waw squashed mask", pend_mask, 32'd0);
      check("waw count", 32'(lq_count), 32'd1);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
      check("waw dead pop wr_en", 32'(wr_en), 32'd0);
      check("waw dead pop count", 32'(lq_count), 32'd0);
      check("waw final r9", dutRf[9], 32'h42);

`ifdef WB_STARVE_LIMIT_EN
      // Starvation: eight ALU cycles over a non-empty FIFO raise the stall.
      doReset();
      applyStimulus(1'b1, 5'd20, 32'h1, 1'b1, 5'd3, 32'h33, acc);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b1, 5'd21, 32'(k), 1'b0, 5'd0, 32'd0, acc);
         check($sformatf("starve k%0d stall", k), 32'(alu_stall), 32'(k == 7));
      end
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
      check("starve pop wr_num", 32'(wr_num), 32'd3);
      check("starve released", 32'(alu_stall), 32'd0);
`endif

      // Randomized run against the model; the producer holds an offered
      // result until it is accepted.
      doReset();
      pv = 1'b0; pn = '0; pd = '0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         pct = ((cyc / 40) % 2) ? 85 : 30;
         av = ($urandom_range(99) < pct) && !mStall;
         if (!pv && $urandom_range(99) < 55) begin
            pv = 1'b1;
            pn = 5'($urandom_range(7));
            pd = $urandom;
         end
         applyStimulus(av, 5'($urandom_range(7)), $urandom, pv, pn, pd, acc);
         if (acc) pv = 1'b0;
      end

      // Reset in the middle of activity discards queued entries.
      applyStimulus(1'b1, 5'd20, 32'h1, 1'b1, 5'd3, 32'h3, acc);
      applyStimulus(1'b1, 5'd21, 32'h2, 1'b1, 5'd4, 32'h4, acc);
      check("pre-reset nonempty", 32'(lq_count != 0), 32'd1);
      doReset();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
      check("post-reset idle wr_en", 32'(wr_en), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
